// File: rtl/matrix_calc_pkg.sv
// Shared definitions for the matrix calculator: parser FSM states and default
// matrix geometry.
package matrix_calc_pkg;

  localparam int unsigned MAX_DIM_DEFAULT    = 5;
  localparam int unsigned ELEM_WIDTH_DEFAULT = 8;
  localparam int unsigned DIM_W              = 3;

  typedef enum logic [2:0] {
    IDLE,
    GET_M,
    GET_N,
    GET_DATA,
    PAD,
    DONE,
    ERR
  } state_t;

  // States in which the inter-byte timer is running.
  function automatic logic timer_active(state_t s);
    return (s == GET_M) || (s == GET_N) || (s == GET_DATA);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Inter-byte timeout counter: counts while enabled, saturates at CYCLES-1 and
// flags expiry there; clear has priority.
module timeout_counter #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned      CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]    LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/matrix_input_parser.sv
// Parses a UART byte stream (m, n, then m*n elements) into row-major element
// writes, zero-padding the frame on inter-byte timeout before committing.
module matrix_input_parser
  import matrix_calc_pkg::*;
#(
  parameter int unsigned MAX_DIM         = MAX_DIM_DEFAULT,
  parameter int unsigned ELEM_WIDTH      = ELEM_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_DEFAULT = 10,
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_DEFAULT * CLK_FREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  wr_en,
  output logic [DIM_W-1:0]      wr_row,
  output logic [DIM_W-1:0]      wr_col,
  output logic [ELEM_WIDTH-1:0] wr_data,
  output logic                  commit,
  output logic [DIM_W-1:0]      m_out,
  output logic [DIM_W-1:0]      n_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W     = $clog2(MAX_DIM * MAX_DIM + 1);
  localparam logic [7:0]  MAX_DIM_B = 8'(MAX_DIM);

  state_t                state, state_d;
  logic [DIM_W-1:0]      m, m_d, n, n_d, row, row_d, col, col_d;
  logic [CNT_W-1:0]      cnt, cnt_d, total;
  logic                  wr_en_d, commit_d;
  logic [DIM_W-1:0]      wr_row_d, wr_col_d, m_out_d, n_out_d;
  logic [ELEM_WIDTH-1:0] wr_data_d, wval;
  logic                  do_wr, do_restart, bad_dim, timeout;

  assign total   = CNT_W'(m) * CNT_W'(n);
  assign bad_dim = (rx_data == 8'd0) || (rx_data > MAX_DIM_B);

  assign busy  = timer_active(state) || (state == PAD);
  assign done  = (state == DONE);
  assign error = (state == ERR);

  timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!timer_active(state) || rx_valid),
    .enable  (timer_active(state)),
    .expired (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m       <= '0;
      n       <= '0;
      row     <= '0;
      col     <= '0;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
      commit  <= 1'b0;
      m_out   <= '0;
      n_out   <= '0;
    end else begin
      m       <= m_d;
      n       <= n_d;
      row     <= row_d;
      col     <= col_d;
      cnt     <= cnt_d;
      wr_en   <= wr_en_d;
      wr_row  <= wr_row_d;
      wr_col  <= wr_col_d;
      wr_data <= wr_data_d;
      commit  <= commit_d;
      m_out   <= m_out_d;
      n_out   <= n_out_d;
    end
  end

  // Element writes (from RX or padding) and restarts share one update path
  // below the case so both sources advance the row/col/count identically.
  always_comb begin
    state_d    = state;
    m_d        = m;
    n_d        = n;
    row_d      = row;
    col_d      = col;
    cnt_d      = cnt;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row;
    wr_col_d   = wr_col;
    wr_data_d  = wr_data;
    commit_d   = 1'b0;
    m_out_d    = m_out;
    n_out_d    = n_out;
    do_wr      = 1'b0;
    do_restart = 1'b0;
    wval       = '0;

    case (state)
      IDLE, DONE, ERR: begin
        if (start) do_restart = 1'b1;
      end
      GET_M, GET_N: begin
        if (rx_valid) begin
          if (bad_dim) begin
            state_d = ERR;
          end else if (state == GET_M) begin
            m_d     = rx_data[DIM_W-1:0];
            state_d = GET_N;
          end else begin
            n_d     = rx_data[DIM_W-1:0];
            state_d = GET_DATA;
          end
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      GET_DATA, PAD: begin
        if (cnt == total) begin
          commit_d = 1'b1;
          m_out_d  = m;
          n_out_d  = n;
          state_d  = DONE;
        end else if (state == PAD) begin
          do_wr = 1'b1;
        end else if (rx_valid) begin
          do_wr = 1'b1;
          wval  = rx_data[ELEM_WIDTH-1:0];
        end else if (timeout) begin
          state_d = PAD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_restart) begin
      state_d = GET_M;
      row_d   = '0;
      col_d   = '0;
      cnt_d   = '0;
    end

    if (do_wr) begin
      wr_en_d   = 1'b1;
      wr_row_d  = row;
      wr_col_d  = col;
      wr_data_d = wval;
      cnt_d     = cnt + 1'b1;
      if (col == n - 1'b1) begin
        col_d = '0;
        row_d = row + 1'b1;
      end else begin
        col_d = col + 1'b1;
      end
    end
  end

endmodule
